// File: rtl/pc16_pkg.sv
// Shared widths and the program-counter type for the pc16 counter and its slices.
package pc16_pkg;
    localparam int PC_WIDTH    = 16;
    localparam int SLICE_WIDTH = 4;
    localparam int NUM_SLICES  = 4;
    localparam int BYTE_WIDTH  = 8;

    typedef logic [PC_WIDTH-1:0] pc_t;
endpackage

// File: rtl/pc16_slice.sv
// 4-bit synchronous counter slice: async clear, synchronous load over count,
// ripple-carry output for chaining into the next slice's ENT.
module pc16_slice
    import pc16_pkg::*;
(
    input  logic                   CLK,
    input  logic                   N_CLR,
    input  logic                   ENP,
    input  logic                   ENT,
    input  logic [SLICE_WIDTH-1:0] PRESET,
    input  logic                   N_LOAD,
    output logic [SLICE_WIDTH-1:0] Q,
    output logic                   RCO
);
    logic [SLICE_WIDTH-1:0] q_r;

    // Slice state: clear, then load, then count when both enables are high.
    always_ff @(posedge CLK or negedge N_CLR) begin
        if (!N_CLR) begin
            q_r <= {SLICE_WIDTH{1'b0}};
        end else if (!N_LOAD) begin
            q_r <= PRESET;
        end else if (ENP && ENT) begin
            q_r <= q_r + {{(SLICE_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

    assign Q   = q_r;
    assign RCO = ENT && (q_r == {SLICE_WIDTH{1'b1}});
endmodule

// File: rtl/pc16.sv
// 16-bit program counter built from four chained pc16_slice counters, with a
// byte staging register for atomic 16-bit loads and a byte-wide tristate read-back.
// Optional sticky wrap flag: define PC16_WRAP_FLAG_EN to compile it in.
module pc16
    import pc16_pkg::*;
(
    input  logic                  CLK,
    input  logic                  N_CLR,
    input  logic                  INC,
    input  logic                  N_STAGE,
    input  logic                  N_LOAD,
    input  logic [BYTE_WIDTH-1:0] DIN,
    input  logic                  N_OE_LO,
    input  logic                  N_OE_HI,
    output logic [PC_WIDTH-1:0]   ADDR,
    output logic [BYTE_WIDTH-1:0] DOUT,
    output logic                  RCO,
    output logic                  WRAP
);
    logic [BYTE_WIDTH-1:0] stage_r;
    pc_t                   addr_s;
    pc_t                   preset_s;
    logic [NUM_SLICES-1:0] rco_s;
    logic [NUM_SLICES-1:0] ent_s;
    logic [1:0]            oe_sel_s;

    // Low byte for the next load; survives loads so it can be reused.
    always_ff @(posedge CLK or negedge N_CLR) begin
        if (!N_CLR) begin
            stage_r <= {BYTE_WIDTH{1'b0}};
        end else if (!N_STAGE) begin
            stage_r <= DIN;
        end else begin
            stage_r <= stage_r;
        end
    end

    // Old stage value is used on a same-edge stage+load, giving atomic commits.
    assign preset_s = {DIN, stage_r};
    assign ent_s    = {rco_s[NUM_SLICES-2:0], 1'b1};

    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
        pc16_slice u_slice (
            .CLK    (CLK),
            .N_CLR  (N_CLR),
            .ENP    (INC),
            .ENT    (ent_s[k]),
            .PRESET (preset_s[k*SLICE_WIDTH +: SLICE_WIDTH]),
            .N_LOAD (N_LOAD),
            .Q      (addr_s[k*SLICE_WIDTH +: SLICE_WIDTH]),
            .RCO    (rco_s[k])
        );
    end

    assign ADDR = addr_s;
    // Top slice's carry already implies every lower slice is at F.
    assign RCO  = INC && rco_s[NUM_SLICES-1];

`ifdef PC16_WRAP_FLAG_EN
    logic wrap_r;

    // Sticky wrap flag: any load clears it, and a load beats a wrap on the same edge.
    always_ff @(posedge CLK or negedge N_CLR) begin
        if (!N_CLR) begin
            wrap_r <= 1'b0;
        end else if (!N_LOAD) begin
            wrap_r <= 1'b0;
        end else if (RCO) begin
            wrap_r <= 1'b1;
        end else begin
            wrap_r <= wrap_r;
        end
    end

    assign WRAP = wrap_r;
`else
    assign WRAP = 1'b0;
`endif

    assign oe_sel_s = {N_OE_HI, N_OE_LO};
    assign DOUT = (oe_sel_s == 2'b11) ? {BYTE_WIDTH{1'bz}} :
                  (oe_sel_s == 2'b10) ? addr_s[BYTE_WIDTH-1:0] :
                  (oe_sel_s == 2'b01) ? addr_s[PC_WIDTH-1:BYTE_WIDTH] :
                                        {BYTE_WIDTH{1'bx}};
endmodule

// File: tb/tb_pc16.sv
// Self-checking bench for pc16: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pc16;
    logic        CLK = 1'b0;
    logic        N_CLR = 1'b1;
    logic        INC = 1'b0;
    logic        N_STAGE = 1'b1;
    logic        N_LOAD = 1'b1;
    logic [7:0]  DIN = 8'h00;
    logic        N_OE_LO = 1'b1;
    logic        N_OE_HI = 1'b1;
    logic [15:0] ADDR;
    logic [7:0]  DOUT;
    logic        RCO;
    logic        WRAP;

`ifdef PC16_WRAP_FLAG_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] m_pc    = 16'h0000;
    logic [7:0]  m_stage = 8'h00;
    logic        m_wrap  = 1'b0;

    pc16 dut (
        .CLK     (CLK),
        .N_CLR   (N_CLR),
        .INC     (INC),
        .N_STAGE (N_STAGE),
        .N_LOAD  (N_LOAD),
        .DIN     (DIN),
        .N_OE_LO (N_OE_LO),
        .N_OE_HI (N_OE_HI),
        .ADDR    (ADDR),
        .DOUT    (DOUT),
        .RCO     (RCO),
        .WRAP    (WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: load beats increment; stage is written independently.
    always @(posedge CLK or negedge N_CLR) begin
        if (!N_CLR) begin
            m_pc    <= 16'h0000;
            m_stage <= 8'h00;
            m_wrap  <= 1'b0;
        end else begin
            if (!N_LOAD) begin
                m_pc   <= {DIN, m_stage};
                m_wrap <= 1'b0;
            end else if (INC) begin
                m_pc <= 16'((32'(m_pc) + 32'd1) % 32'd65536);
                if (m_pc == 16'hFFFF && WRAP_EN) m_wrap <= 1'b1;
            end
            if (!N_STAGE) m_stage <= DIN;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        check("addr", 32'(ADDR), 32'(m_pc));
        check("rco", 32'(RCO), 32'(INC && m_pc == 16'hFFFF));
        check("wrap", 32'(WRAP), 32'(m_wrap));
        if (!N_OE_LO && N_OE_HI) check("dout_lo", 32'(DOUT), 32'(m_pc[7:0]));
        if (N_OE_LO && !N_OE_HI) check("dout_hi", 32'(DOUT), 32'(m_pc[15:8]));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load16(input logic [15:0] v);
        N_STAGE = 1'b0; DIN = v[7:0];
        tick();
        N_STAGE = 1'b1; N_LOAD = 1'b0; DIN = v[15:8];
        tick();
        N_LOAD = 1'b1;
    endtask

    initial begin
        #1 N_CLR = 1'b0;
        N_OE_LO = 1'b0;
        #1;
        check("reset_addr", 32'(ADDR), 32'h0000);
        check("reset_wrap", 32'(WRAP), 32'h0);
        check("reset_dout_lo", 32'(DOUT), 32'h00);
        N_OE_LO = 1'b1;

        // Release reset between edges with INC already high
        #10 N_CLR = 1'b1; INC = 1'b1;
        repeat (3) tick();
        check("count3", 32'(ADDR), 32'h0003);
        INC = 1'b0;

        // Staged load of 1234 and byte read-back
        N_STAGE = 1'b0; DIN = 8'h34;
        tick();
        N_STAGE = 1'b1; N_LOAD = 1'b0; DIN = 8'h12;
        tick();
        N_LOAD = 1'b1;
        check("load_1234", 32'(ADDR), 32'h1234);
        N_OE_HI = 1'b0; #1;
        check("dout_hi_12", 32'(DOUT), 32'h12);
        N_OE_HI = 1'b1; N_OE_LO = 1'b0; #1;
        check("dout_lo_34", 32'(DOUT), 32'h34);
        N_OE_LO = 1'b1;

        // Carry between slices
        load16(16'h00FF); INC = 1'b1; #1;
        check("rco_00ff", 32'(RCO), 32'h0);
        tick(); INC = 1'b0;
        check("carry_0100", 32'(ADDR), 32'h0100);
        load16(16'h0FFF); INC = 1'b1; #1;
        check("rco_0fff", 32'(RCO), 32'h0);
        tick(); INC = 1'b0;
        check("carry_1000", 32'(ADDR), 32'h1000);

        // Wrap from FFFF, then cleared by a load
        load16(16'hFFFF); INC = 1'b1; #1;
        check("rco_ffff", 32'(RCO), 32'h1);
        tick(); INC = 1'b0;
        check("wrap_addr", 32'(ADDR), 32'h0000);
        check("wrap_set", 32'(WRAP), 32'(WRAP_EN));
        load16(16'h0001);
        check("wrap_clr", 32'(WRAP), 32'h0);

        // Load and INC together at FFFF: load wins, RCO not gated by load
        load16(16'hFFFF);
        INC = 1'b1; N_LOAD = 1'b0; DIN = 8'h55; #1;
        check("rco_with_load", 32'(RCO), 32'h1);
        tick(); INC = 1'b0; N_LOAD = 1'b1;
        check("load_wins", 32'(ADDR), 32'h55FF);
        check("load_wins_wrap", 32'(WRAP), 32'h0);

        // Stage and load together: load uses old stage, new byte is retained
        N_STAGE = 1'b0; N_LOAD = 1'b0; DIN = 8'h77;
        tick();
        N_STAGE = 1'b1; DIN = 8'h11;
        check("stage_load_old", 32'(ADDR), 32'h77FF);
        tick(); N_LOAD = 1'b1;
        check("stage_retained", 32'(ADDR), 32'h1177);

        // Reset between stage and load discards the staged byte
        N_STAGE = 1'b0; DIN = 8'hAB;
        tick(); N_STAGE = 1'b1;
        #1 N_CLR = 1'b0;
        #1 N_CLR = 1'b1;
        N_LOAD = 1'b0; DIN = 8'hCD;
        tick(); N_LOAD = 1'b1;
        check("midreset_load", 32'(ADDR), 32'hCD00);

        // Randomized traffic, biased toward FF bytes so wraps happen
        for (int i = 0; i < 600; i++) begin
            int oe;
            INC     = ($urandom_range(0, 9) < 8);
            N_STAGE = ($urandom_range(0, 9) >= 3);
            N_LOAD  = ($urandom_range(0, 9) >= 1);
            DIN     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            oe      = $urandom_range(0, 2);
            N_OE_LO = (oe != 1);
            N_OE_HI = (oe != 2);
            if ($urandom_range(0, 99) == 0) begin
                #1 N_CLR = 1'b0;
                #1 N_CLR = 1'b1;
            end
            tick();
        end

        N_OE_LO = 1'b1; N_OE_HI = 1'b1; INC = 1'b0; N_LOAD = 1'b1; N_STAGE = 1'b1;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
